y_muldiv: RTL and testbench

Y_MULDIV -- requirements
Module: y_muldiv

---
 rtl/y_muldiv.sv | 140 ++++++++++++++
 tb/tb_y_muldiv.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/y_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle, WIDTH cycles per operation.
// Define Y_MULDIV_SIGNED_EN to enable signed operands via op[2].
module y_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] result
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] ITER = WIDTH'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, a_q, a_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         op_q, op_d;
  logic               dz_q, dz_d, dbz_q, dbz_d;
  logic               accept, last;
  logic [WIDTH-1:0]   ua, ub;
  logic [WIDTH:0]     add_s, rs, sub_s;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] p_raw, p_fin;
  logic [WIDTH-1:0]   q_fin, r_fin;

  assign accept = start && (state_q != S_BUSY);
  assign last   = (state_q == S_BUSY) && (cnt_q == WIDTH'(1));

  // hi/lo hold {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  assign add_s = {1'b0, hi_q} + {1'b0, opb_q};
  assign rs    = {hi_q, lo_q[WIDTH-1]};
  assign sub_s = rs - {1'b0, opb_q};
  assign {step_hi, step_lo} = op_q[1]
    ? {(sub_s[WIDTH] ? rs[WIDTH-1:0] : sub_s[WIDTH-1:0]), lo_q[WIDTH-2:0], ~sub_s[WIDTH]}
    : (lo_q[0] ? {add_s, lo_q[WIDTH-1:1]} : {1'b0, hi_q, lo_q[WIDTH-1:1]});
  assign p_raw = {step_hi, step_lo};

`ifdef Y_MULDIV_SIGNED_EN
  // Datapath runs on magnitudes; the sign is reapplied to the final value.
  logic neg_q, a_neg, b_neg;
  assign a_neg = op[2] & a[WIDTH-1];
  assign b_neg = op[2] & b[WIDTH-1];
  assign ua    = a_neg ? -a : a;
  assign ub    = b_neg ? -b : b;
  always_ff @(posedge clk) begin
    if (!rst_n)      neg_q <= 1'b0;
    else if (accept) neg_q <= (op[1:0] == 2'b11) ? a_neg : (a_neg ^ b_neg);
  end
  assign p_fin = neg_q ? -p_raw : p_raw;
  assign q_fin = neg_q ? -step_lo : step_lo;
  assign r_fin = neg_q ? -step_hi : step_hi;
`else
  logic unused_sgn;
  assign unused_sgn = op[2];
  assign ua    = a;
  assign ub    = b;
  assign p_fin = p_raw;
  assign q_fin = step_lo;
  assign r_fin = step_hi;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    a_d      = a_q;
    op_d     = op_q;
    dz_d     = dz_q;
    dbz_d    = dbz_q;
    result_d = result_q;
    if (accept) begin
      state_d = S_BUSY;
      cnt_d   = ITER;
      hi_d    = '0;
      lo_d    = ua;
      opb_d   = ub;
      a_d     = a;
      op_d    = op[1:0];
      dz_d    = op[1] && (b == '0);
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - WIDTH'(1);
      hi_d  = step_hi;
      lo_d  = step_lo;
      if (last) begin
        state_d = S_DONE;
        dbz_d   = dz_q;
        case (op_q)
          2'b00:   result_d = p_fin[WIDTH-1:0];
          2'b01:   result_d = p_fin[2*WIDTH-1:WIDTH];
          2'b10:   result_d = dz_q ? '1 : q_fin;
          default: result_d = dz_q ? a_q : r_fin;
        endcase
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      a_q      <= '0;
      op_q     <= '0;
      dz_q     <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      a_q      <= a_d;
      op_q     <= op_d;
      dz_q     <= dz_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign dbz    = dbz_q;
  assign result = result_q;
endmodule

// File: tb/tb_y_muldiv.sv
// Bench for y_muldiv: directed vector table, random ops vs arithmetic model, corner sequences.
module tb_y_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] result;
  int checks = 0, errors = 0;

  y_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dbz(dbz), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic         z;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic z);
    logic [63:0] p;
    longint sx, sy;
    z = o[1] && (y == 0);
    p = {32'b0, x} * {32'b0, y};
    r = '0;
    case (o[1:0])
      2'd0: r = p[31:0];
      2'd1: r = p[63:32];
      2'd2: if (z) r = '1; else r = x / y;
      default: if (z) r = x; else r = x % y;
    endcase
`ifdef Y_MULDIV_SIGNED_EN
    if (o[2]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = 64'(sx * sy);
      case (o[1:0])
        2'd0: r = p[31:0];
        2'd1: r = p[63:32];
        2'd2: if (z) r = '1; else r = 32'(sx / sy);
        default: if (z) r = x; else r = 32'(sx % sy);
      endcase
    end
`endif
  endfunction

  // Called at the negedge right after the accepting edge; returns at the negedge where done is seen.
  task automatic wait_done(output int lat, output int bc);
    lat = 1; bc = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=%0d required=%0d", lat, W + 1);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic z, output int lat, output int bc);
    @(negedge clk);
    chk("done_single_pulse", {63'b0, done}, 64'd0);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    wait_done(lat, bc);
    r = result; z = dbz;
  endtask

  logic [W-1:0] r, er, ra, rb;
  logic         z, ez;
  logic [2:0]   ro;
  int           lat, bc, npulse;

  initial begin
    vecs.push_back('{3'd0, 32'd7, 32'd6, 32'd42, 1'b0});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0});
    vecs.push_back('{3'd2, 32'd100, 32'd7, 32'd14, 1'b0});
    vecs.push_back('{3'd3, 32'd100, 32'd7, 32'd2, 1'b0});
    vecs.push_back('{3'd2, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{3'd3, 32'd5, 32'd0, 32'd5, 1'b1});
    vecs.push_back('{3'd1, 32'h80000000, 32'd4, 32'd2, 1'b0});
`ifdef Y_MULDIV_SIGNED_EN
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{3'd7, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0});
    vecs.push_back('{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{3'd5, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b1});
`else
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 1'b0});
`endif

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_dbz", {63'b0, dbz}, 64'd0);
    chk("reset_result", {32'b0, result}, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, bc);
      chk($sformatf("vec%0d_result", i), {32'b0, r}, {32'b0, vecs[i].r});
      chk($sformatf("vec%0d_dbz", i), {63'b0, z}, {63'b0, vecs[i].z});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(W));
    end

    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom);
      ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, er, ez);
      do_op(ro, ra, rb, r, z, lat, bc);
      chk($sformatf("rand%0d_op%0d_%h_%h_result", i, ro, ra, rb), {32'b0, r}, {32'b0, er});
      chk($sformatf("rand%0d_dbz", i), {63'b0, z}, {63'b0, ez});
      if (lat != W + 1) chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(W + 1));
    end

    // back-to-back: REM accepted in the DIV's done cycle
    do_op(3'd2, 32'd100, 32'd7, r, z, lat, bc);
    chk("b2b_div_result", {32'b0, r}, 64'd14);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; op = '0;
    chk("b2b_busy_after_done", {63'b0, busy}, 64'd1);
    chk("b2b_result_held", {32'b0, result}, 64'd14);
    wait_done(lat, bc);
    chk("b2b_rem_result", {32'b0, result}, 64'd2);
    chk("b2b_rem_latency", 64'(lat), 64'(W + 1));
    repeat (3) @(negedge clk);
    chk("hold_result", {32'b0, result}, 64'd2);
    chk("hold_done_low", {63'b0, done}, 64'd0);

    // start pulsed mid-operation is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) npulse++;
      @(negedge clk);
    end
    chk("busy_start_pulses", 64'(npulse), 64'd1);
    chk("busy_start_result", {32'b0, result}, 64'd15);
    chk("busy_start_dbz", {63'b0, dbz}, 64'd0);

    // reset in BUSY cycle 10, with start held during reset
    do_op(3'd2, 32'd5, 32'd0, r, z, lat, bc);
    chk("pre_reset_dbz", {63'b0, z}, 64'd1);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_result", {32'b0, result}, 64'd0);
    chk("midrst_dbz", {63'b0, dbz}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    rst_n = 1'b1; start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) npulse++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(npulse), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
